// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator command sequencer.
package acc_seq_pkg;

    localparam int unsigned ACC_W     = 8;
    localparam int unsigned ACC_IMM_W = 4;

    // Command codes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_REG = 2'd1,
        OP_ALU = 2'd2,
        OP_IMM = 2'd3
    } acc_op_e;

    // Sequencer states. The top keeps its state register as plain logic.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_IMM_LO = 2'd2,
        S_IMM_HI = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Command handshake between the decode stage (master) and the sequencer (slave).
interface acc_seq_ctrl_if #(
    parameter int unsigned W = 8
) ();

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/acc_seq_perf.sv
// Saturating write and stall counters for the sequencer.
// Only instantiated when ACC_SEQ_PERF_EN is defined.
module acc_seq_perf (
    input  logic        clk,
    input  logic        Reset,
    input  logic        write_en_i,
    input  logic        stall_i,
    output logic [15:0] perf_writes_o,
    output logic [15:0] perf_stall_o
);

    logic [15:0] writes_q, writes_d;
    logic [15:0] stall_q, stall_d;

    // Next-state: count up, holding at all-ones.
    always_comb begin
        writes_d = writes_q;
        stall_d  = stall_q;
        if (write_en_i && (writes_q != 16'hFFFF)) writes_d = writes_q + 16'd1;
        if (stall_i && (stall_q != 16'hFFFF))     stall_d  = stall_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            writes_q <= '0;
            stall_q  <= '0;
        end else begin
            writes_q <= writes_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_writes_o = writes_q;
    assign perf_stall_o  = stall_q;

endmodule

// File: rtl/acc_seq_ctrl.sv
// Accumulator command sequencer: turns handshaked micro-commands into registered
// accumulator write/select controls; LOAD_IMM is split into low then high nibble.
// Optional macro ACC_SEQ_PERF_EN adds perf_writes / perf_stall counters.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int unsigned W     = ACC_W,
    parameter int unsigned IMM_W = ACC_IMM_W
) (
    input  logic             clk,
    input  logic             Reset,
    acc_seq_ctrl_if.slave    cmd,
    output logic             done,
    output logic             Write_En,
    output logic             From_Reg,
    output logic             From_Imm,
    output logic             From_ALU,
    output logic             Load_Hi,
    output logic [W-1:0]     RegInput,
    output logic [W-1:0]     ALUInput,
    output logic [IMM_W-1:0] Imm_in
`ifdef ACC_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_writes,
    output logic [15:0]      perf_stall
`endif
);

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_ISSUE  = S_ISSUE;
    localparam logic [1:0] ST_IMM_LO = S_IMM_LO;
    localparam logic [1:0] ST_IMM_HI = S_IMM_HI;

    logic [1:0]       state_q, state_d;
    logic             write_en_q, write_en_d;
    logic             from_reg_q, from_reg_d;
    logic             from_imm_q, from_imm_d;
    logic             from_alu_q, from_alu_d;
    logic             load_hi_q, load_hi_d;
    logic             done_q, done_d;
    logic [W-1:0]     reg_input_q, reg_input_d;
    logic [W-1:0]     alu_input_q, alu_input_d;
    logic [IMM_W-1:0] imm_in_q, imm_in_d;
    logic [IMM_W-1:0] data_hi_q, data_hi_d;  // high nibble parked for the IMM_HI write
    logic             accept;

    // Ready depends on state only; the IMM_LO cycle is the single stall slot.
    assign cmd.cmd_ready = (state_q != ST_IMM_LO);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Next-state and next-output decode; outputs describe the state being entered.
    always_comb begin
        state_d     = ST_IDLE;
        write_en_d  = 1'b0;
        from_reg_d  = 1'b0;
        from_imm_d  = 1'b0;
        from_alu_d  = 1'b0;
        load_hi_d   = 1'b0;
        done_d      = 1'b0;
        reg_input_d = reg_input_q;
        alu_input_d = alu_input_q;
        imm_in_d    = imm_in_q;
        data_hi_d   = data_hi_q;
        if (state_q == ST_IMM_LO) begin
            state_d    = ST_IMM_HI;
            write_en_d = 1'b1;
            from_imm_d = 1'b1;
            load_hi_d  = 1'b1;
            done_d     = 1'b1;
            imm_in_d   = data_hi_q;
        end else if (accept) begin
            // IDLE, ISSUE and IMM_HI all dispatch the same way.
            case (cmd.cmd_op)
                OP_REG: begin
                    state_d     = ST_ISSUE;
                    write_en_d  = 1'b1;
                    from_reg_d  = 1'b1;
                    done_d      = 1'b1;
                    reg_input_d = cmd.cmd_data;
                end
                OP_ALU: begin
                    state_d     = ST_ISSUE;
                    write_en_d  = 1'b1;
                    from_alu_d  = 1'b1;
                    done_d      = 1'b1;
                    alu_input_d = cmd.cmd_data;
                end
                OP_IMM: begin
                    state_d    = ST_IMM_LO;
                    write_en_d = 1'b1;
                    from_imm_d = 1'b1;
                    imm_in_d   = cmd.cmd_data[IMM_W-1:0];
                    data_hi_d  = cmd.cmd_data[W-1:IMM_W];
                end
                default: state_d = ST_IDLE;  // NOP
            endcase
        end
    end

    // State and registered accumulator controls.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            write_en_q  <= 1'b0;
            from_reg_q  <= 1'b0;
            from_imm_q  <= 1'b0;
            from_alu_q  <= 1'b0;
            load_hi_q   <= 1'b0;
            done_q      <= 1'b0;
            reg_input_q <= '0;
            alu_input_q <= '0;
            imm_in_q    <= '0;
            data_hi_q   <= '0;
        end else begin
            state_q     <= state_d;
            write_en_q  <= write_en_d;
            from_reg_q  <= from_reg_d;
            from_imm_q  <= from_imm_d;
            from_alu_q  <= from_alu_d;
            load_hi_q   <= load_hi_d;
            done_q      <= done_d;
            reg_input_q <= reg_input_d;
            alu_input_q <= alu_input_d;
            imm_in_q    <= imm_in_d;
            data_hi_q   <= data_hi_d;
        end
    end

    assign Write_En = write_en_q;
    assign From_Reg = from_reg_q;
    assign From_Imm = from_imm_q;
    assign From_ALU = from_alu_q;
    assign Load_Hi  = load_hi_q;
    assign done     = done_q;
    assign RegInput = reg_input_q;
    assign ALUInput = alu_input_q;
    assign Imm_in   = imm_in_q;

`ifdef ACC_SEQ_PERF_EN
    acc_seq_perf u_perf (
        .clk           (clk),
        .Reset         (Reset),
        .write_en_i    (write_en_q),
        .stall_i       (cmd.cmd_valid && !cmd.cmd_ready),
        .perf_writes_o (perf_writes),
        .perf_stall_o  (perf_stall)
    );
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: stimulus pushes expected write cycles,
// a negedge monitor pops and compares each Write_En cycle.
module tb_acc_seq_ctrl;
    import acc_seq_pkg::*;

    typedef struct packed {
        logic       fr;
        logic       fa;
        logic       fi;
        logic       lh;
        logic       dn;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       Reset;
    logic       done, Write_En, From_Reg, From_Imm, From_ALU, Load_Hi;
    logic [7:0] RegInput, ALUInput;
    logic [3:0] Imm_in;
`ifdef ACC_SEQ_PERF_EN
    logic [15:0] perf_writes, perf_stall;
`endif

    acc_seq_ctrl_if #(.W(8)) cmd_bus ();

    acc_seq_ctrl dut (
        .clk      (clk),
        .Reset    (Reset),
        .cmd      (cmd_bus),
        .done     (done),
        .Write_En (Write_En),
        .From_Reg (From_Reg),
        .From_Imm (From_Imm),
        .From_ALU (From_ALU),
        .Load_Hi  (Load_Hi),
        .RegInput (RegInput),
        .ALUInput (ALUInput),
        .Imm_in   (Imm_in)
`ifdef ACC_SEQ_PERF_EN
        ,
        .perf_writes (perf_writes),
        .perf_stall  (perf_stall)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [7:0] acc_model = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Simple accumulator model to observe the end result of a command.
    always @(posedge clk) begin
        if (Reset && Write_En) begin
            if (From_Reg)      acc_model = RegInput;
            else if (From_ALU) acc_model = ALUInput;
            else if (From_Imm) begin
                if (Load_Hi) acc_model[7:4] = Imm_in;
                else         acc_model[3:0] = Imm_in;
            end
        end
    end

    // Monitor: every write cycle must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        logic [12:0] act;
        logic [12:0] req;
        if (Reset) begin
            n_checks++;
            if (Write_En) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: sel=%b%b%b lh=%b, expected no write",
                             From_Reg, From_ALU, From_Imm, Load_Hi);
                end else begin
                    e   = exp_q.pop_front();
                    act = {From_Reg, From_ALU, From_Imm, Load_Hi, done,
                           e.fr ? RegInput : (e.fa ? ALUInput : {4'h0, Imm_in})};
                    req = e;
                    if (act !== req) begin
                        n_fail++;
                        $display("FAIL write_cycle: got 'h%0h, expected 'h%0h", act, req);
                    end
                end
            end else if ({From_Reg, From_ALU, From_Imm, Load_Hi, done} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_selects: got %b, expected 00000",
                         {From_Reg, From_ALU, From_Imm, Load_Hi, done});
            end
        end
    end

    // Present a command, push its expected writes, return #1 after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        logic rdy;
        int   waited;
        logic got;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        case (op)
            OP_REG: exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, data});
            OP_ALU: exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, data});
            OP_IMM: begin
                exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, data[3:0]});
                exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, data[7:4]});
            end
            default: ;
        endcase
        waited = 0;
        got    = 1'b0;
        while (!got) begin
            @(negedge clk);
            rdy = cmd_bus.cmd_ready;
            @(posedge clk);
            if (rdy) got = 1'b1;
            else begin
                waited++;
                if (waited > 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
                    got = 1'b1;
                end
            end
        end
        #1;
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {6'b0, Write_En, From_Reg, From_Imm, From_ALU, Load_Hi, done,
                RegInput, ALUInput, Imm_in};
    endfunction

    initial begin
        Reset             = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_NOP;
        cmd_bus.cmd_data  = 8'h00;
        idle(3);
        Reset = 1'b1;
        chk("reset_outputs", all_outs(), 32'h0);
        chk("ready_after_reset", {31'b0, cmd_bus.cmd_ready}, 32'd1);
        idle(1);

        // Single LOAD_REG.
        send(OP_REG, 8'h5A);
        chk("reg_write", {Write_En, From_Reg, done, RegInput}, {3'b111, 8'h5A});
        idle(1);
        chk("reg_after", {Write_En, From_Reg, From_ALU, From_Imm, done}, 5'b0);
        chk("acc_5a", {24'b0, acc_model}, 32'h5A);

        // Back-to-back REG then ALU.
        send(OP_REG, 8'h11);
        chk("b2b_ready1", {31'b0, cmd_bus.cmd_ready}, 32'd1);
        send(OP_ALU, 8'hA5);
        chk("b2b_ready2", {31'b0, cmd_bus.cmd_ready}, 32'd1);
        chk("b2b_alu", {Write_En, From_ALU, From_Reg, ALUInput}, {3'b110, 8'hA5});
        idle(2);
        chk("acc_a5", {24'b0, acc_model}, 32'hA5);

        // LOAD_IMM split into two nibble writes.
        send(OP_IMM, 8'hCF);
        chk("imm_lo_ready", {31'b0, cmd_bus.cmd_ready}, 32'd0);
        chk("imm_lo", {Load_Hi, From_Imm, done, Imm_in}, {3'b010, 4'hF});
        idle(1);
        chk("imm_hi", {cmd_bus.cmd_ready, Load_Hi, From_Imm, done, Imm_in}, {4'b1111, 4'hC});
        idle(1);
        chk("acc_cf", {24'b0, acc_model}, 32'hCF);

        // NOP accepted in ISSUE: the REG write still completes, then no write.
        send(OP_REG, 8'h22);
        send(OP_NOP, 8'hFF);
        chk("nop_no_write", {31'b0, Write_En}, 32'd0);
        idle(2);
        chk("acc_22", {24'b0, acc_model}, 32'h22);

        // Reset during IMM_LO aborts the high nibble; valid held across reset.
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_IMM;
        cmd_bus.cmd_data  = 8'h3B;
        @(posedge clk);
        #1;
        chk("abort_in_lo", {cmd_bus.cmd_ready, Write_En, Imm_in}, {2'b01, 4'hB});
        #1;
        Reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'h0);
        chk("async_reset_ready", {31'b0, cmd_bus.cmd_ready}, 32'd1);
        cmd_bus.cmd_op   = OP_REG;
        cmd_bus.cmd_data = 8'h77;
        idle(2);
        Reset = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77});
        idle(1);
        chk("accept_after_reset", {Write_En, From_Reg, RegInput}, {2'b11, 8'h77});
        cmd_bus.cmd_valid = 1'b0;
        idle(2);

        // Counters start clean for the stall/throughput sequence.
        Reset = 1'b0;
        idle(1);
        Reset = 1'b1;
        idle(1);
        send(OP_REG, 8'h01);
        send(OP_REG, 8'h02);
        send(OP_REG, 8'h03);
        send(OP_IMM, 8'h4D);
        send(OP_NOP, 8'h00);  // stalls once in IMM_LO, accepted in IMM_HI
        idle(3);
        chk("acc_4d", {24'b0, acc_model}, 32'h4D);
`ifdef ACC_SEQ_PERF_EN
        chk("perf_writes", {16'b0, perf_writes}, 32'd5);
        chk("perf_stall", {16'b0, perf_stall}, 32'd1);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
